// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control unit: sequences fetch/decode/execute/memory/writeback
// and owns the PC and instruction register; the datapath supplies ALU status flags.
module multicycle_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        negative,
    input  logic        overflow,
    input  logic        zero,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        write_rb,
    output logic        alu_source,
    output logic [3:0]  alu_control,
    output logic [4:0]  rs_1,
    output logic [4:0]  rs_2,
    output logic [4:0]  rd_0,
    output logic [31:0] immediate,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic        halted
);

    // state     | meaning
    // FETCH     | request instruction at pc, wait for imem_ready, latch IR
    // DECODE    | one cycle; illegal opcode / branch funct3 traps to HALT
    // EXECUTE   | one cycle; resolve branch, compute and commit next pc
    // MEMORY    | hold dmem_req until dmem_ready
    // WRITEBACK | one cycle of register-bank write
    // HALT      | trapped; only rst leaves
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        halted_q, halted_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_ralu, is_ialu, is_lw, is_sw, is_branch, is_lui, is_jal;
    logic        branch_ok, legal, taken;
    logic [31:0] next_pc;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_ralu   = (opcode == OP_RALU);
    assign is_ialu   = (opcode == OP_IALU);
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_lui    = (opcode == OP_LUI);
    assign is_jal    = (opcode == OP_JAL);

    // Only BEQ/BNE/BLT/BGE are implemented; unsigned compares trap.
    assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
    assign legal     = is_ralu || is_ialu || is_lw || is_sw || is_lui || is_jal ||
                       (is_branch && branch_ok);

    assign rs_1 = ir_q[19:15];
    assign rs_2 = ir_q[24:20];
    assign rd_0 = ir_q[11:7];

    always_comb begin
        immediate = 32'h0;
        case (opcode)
            OP_IALU, OP_LW: immediate = {{20{ir_q[31]}}, ir_q[31:20]};
            OP_SW:          immediate = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH:      immediate = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                         ir_q[11:8], 1'b0};
            OP_LUI:         immediate = {ir_q[31:12], 12'h000};
            OP_JAL:         immediate = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                                         ir_q[30:21], 1'b0};
            default:        immediate = 32'h0;
        endcase
    end

    always_comb begin
        alu_control = 4'b0000;
        alu_source  = 1'b0;
        wb_sel      = 2'b00;
        if (is_ralu) begin
            alu_control = {ir_q[30], funct3};
            alu_source  = 1'b1;
        end else if (is_ialu) begin
            // bit 30 is an immediate bit except for the shift-right encodings
            alu_control = {(funct3 == 3'b101) ? ir_q[30] : 1'b0, funct3};
        end else if (is_branch) begin
            alu_control = 4'b1000;
            alu_source  = 1'b1;
        end
        if (is_lw)  wb_sel = 2'b01;
        if (is_jal) wb_sel = 2'b10;
        if (is_lui) wb_sel = 2'b11;
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = negative ^ overflow;
            3'b101:  taken = !(negative ^ overflow);
            default: taken = 1'b0;
        endcase
        taken   = taken && is_branch;
        next_pc = pc_q + ((taken || is_jal) ? immediate : 32'd4);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (next_pc[1:0] != 2'b00) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    pc_d = next_pc;
                    if (is_lw || is_sw)  state_d = S_MEMORY;
                    else if (is_branch)  state_d = S_FETCH;
                    else                 state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (dmem_ready) state_d = is_sw ? S_FETCH : S_WRITEBACK;
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Strobes are masked by rst so a pending access is dropped in the reset cycle itself.
    assign imem_req  = (state_q == S_FETCH) && !rst;
    assign dmem_req  = (state_q == S_MEMORY) && !rst;
    assign dmem_we   = (state_q == S_MEMORY) && is_sw && !rst;
    assign write_rb  = (state_q == S_WRITEBACK) && !rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these parameters:
- RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising-edge.
- rst, in, 1: synchronous, active-high reset.
- imem_rdata, in, 32: fetched instruction.
- imem_ready, in, 1: instruction fetch complete.
- dmem_ready, in, 1: data access complete.
- negative, overflow, zero, in, 1 each: datapath ALU status.
- imem_req, out, 1: fetch request.
- imem_addr, out, 32: fetch address (= pc).
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: 1 = store, 0 = load.
- write_rb, out, 1: register-bank write enable.
- alu_source, out, 1: 1 = rs2 to ALU B, 0 = immediate.
- alu_control, out, 4: ALU operation.
- rs_1, rs_2, rd_0, out, 5 each: register indices.
- immediate, out, 32: sign-extended immediate.
- wb_sel, out, 2: writedata mux select (00 ALU, 01 dmem, 10 pc+4, 11 immediate).
- pc, out, 32: current PC.
- halted, out, 1: sticky trap flag.

Function
REQ-003 The block SHALL use the states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and HALT.
REQ-004 The block SHALL support these opcodes only: 0110011 R-ALU, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ/BNE/BLT/BGE, 0110111 LUI, 1101111 JAL.
REQ-005 In FETCH, imem_req SHALL be 1 and held until imem_ready=1, at which edge the IR SHALL latch imem_rdata and the state SHALL go to DECODE; there SHALL be no timeout.
REQ-006 DECODE SHALL take one cycle, then go to EXECUTE for supported opcodes, or to HALT with halted=1 for any other opcode, or for BRANCH funct3 of 010, 011, 110 or 111.
REQ-007 rs_1, rs_2 and rd_0 SHALL equal IR[19:15], IR[24:20] and IR[11:7], and immediate SHALL be the RV32I I/S/B/U/J format selected by opcode, all combinational from the IR.
REQ-008 alu_control SHALL be:
- R-ALU: {IR[30], funct3}.
- I-ALU: {IR[30] only when funct3=101, else 0, funct3}.
- LW, SW, LUI, JAL: 4'b0000 (ADD).
- BRANCH: 4'b1000 (SUB).
REQ-009 alu_source SHALL be 1 for R-ALU and BRANCH, and 0 otherwise.
REQ-010 EXECUTE SHALL take one cycle, then go to:
- LW, SW: MEMORY.
- BRANCH: FETCH.
- Others: WRITEBACK.
REQ-011 For BRANCH in EXECUTE, taken SHALL be:
- BEQ: zero.
- BNE: !zero.
- BLT: negative^overflow.
- BGE: !(negative^overflow).
REQ-012 pc SHALL update only on the EXECUTE exit edge:
- Taken BRANCH or JAL: pc+immediate.
- All others: pc+4.
- Arithmetic is modulo 2^32 and wraps without error.
REQ-013 A computed next-pc with bits [1:0] != 0 SHALL NOT be loaded; the state SHALL go to HALT with halted=1 and pc unchanged.
REQ-014 In MEMORY, dmem_req SHALL be 1 (dmem_we=1 for SW) and held until dmem_ready=1; then SW SHALL go to FETCH and LW to WRITEBACK.
REQ-015 WRITEBACK SHALL last one cycle with write_rb=1, then go to FETCH; wb_sel SHALL be 00 for ALU ops, 01 for LW, 10 for JAL and 11 for LUI.
REQ-016 write_rb SHALL be 1 only in WRITEBACK; writes to rd_0=0 SHALL still assert write_rb, since the register file ignores x0.
REQ-017 HALT SHALL be absorbing; only rst exits it.
REQ-018 Zero-wait cycle counts, FETCH entry to next FETCH entry, SHALL be:
- BRANCH and JAL target: 3.
- R-ALU, I-ALU, LUI, JAL link: 4.
- SW: 4.
- LW: 5.
- Each wait cycle adds 1.

Reset
REQ-019 While rst=1 at a clock edge:
- The state SHALL go to FETCH, pc to RESET_PC, IR to 0 and halted to 0.
- During the rst cycle, imem_req, dmem_req, dmem_we and write_rb SHALL be 0.
REQ-020 imem_req SHALL be first asserted in the first cycle after rst deasserts.
REQ-021 Reset mid-operation, including with imem_req or dmem_req pending, SHALL abandon the access with no register write.

Verification
REQ-022 The bench SHALL cover at least these scenarios:
- ADD x3,x1,x2 with zero-wait: write_rb=1 on cycle 4 only, alu_control=0000, alu_source=1, wb_sel=00, pc 0→4.
- LW x5,8(x1) with dmem_ready delayed 3 cycles: dmem_req held 4 cycles, dmem_we=0, then write_rb=1 with wb_sel=01, 8 cycles total.
- BEQ with zero=1, imm=-8, pc=0x10: next pc=0x08, no write_rb; repeated with zero=0: next pc=0x14.
- JAL x1,+6 (misaligned): halted=1, pc unchanged, imem_req=0 thereafter until rst.
- Opcode 0001111: HALT after DECODE, write_rb never asserted.
- rst during MEMORY of SW: dmem_req=0 in the rst cycle, pc=RESET_PC, FETCH the next cycle.
